ascon_round_engine: RTL and testbench

Iterative Ascon-p[n] permutation engine per NIST SP 800-232. Accepts a 320-bit state and a round count of 0..12, applies the last n rounds of Ascon-p (constant addition, substitution, linear diffusion), and returns the permuted state over a valid/ready handshake. It generalises the single-round constant addition layer into a multi-cycle, parametrically unrolled core, and sits between the AEAD/hash mode controllers and the state register file.

---
 rtl/ascon_round_engine_pkg.sv | 27 ++
 rtl/ascon_round_engine_if.sv | 26 ++
 rtl/ascon_round_engine_round.sv | 60 ++++++
 rtl/ascon_round_engine.sv | 108 ++++++++++
 tb/tb_ascon_round_engine.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_round_engine_pkg.sv
// ascon_pkg: shared types and constants for the Ascon-p round engine.
//   ascon_state_t  : 320-bit state, word [0] = x0 ... word [4] = x4
//   rnd_t          : round index 0..12 into the round-constant table
//   rnd_cnt_t      : 4-bit round count
//   engine_state_e : engine FSM states
//   ASCON_RC_LUT   : round constants, padded with zeros past index 11 so that
//                    bypassed round slots can index it safely.
package ascon_pkg;

   localparam int ASCON_MAX_ROUNDS = 12;

   typedef logic [3:0]        rnd_t;
   typedef logic [3:0]        rnd_cnt_t;
   typedef logic [0:4][63:0]  ascon_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } engine_state_e;

   localparam logic [0:15][7:0] ASCON_RC_LUT = {
      8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
      8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/ascon_round_engine_if.sv
// Request/result handshake bundle for ascon_round_engine.
//   in_valid_i / in_ready_o : request handshake (rounds_i, state_i)
//   out_valid_o / out_ready_i : result handshake (state_o)
// slave modport is the engine side, master modport the mode-controller side.
interface ascon_round_engine_if;
   import ascon_pkg::*;

   logic         in_valid_i;
   logic         in_ready_o;
   rnd_cnt_t     rounds_i;
   ascon_state_t state_i;
   logic         out_valid_o;
   logic         out_ready_i;
   ascon_state_t state_o;

   modport slave (
      input  in_valid_i, rounds_i, state_i, out_ready_i,
      output in_ready_o, out_valid_o, state_o
   );

   modport master (
      output in_valid_i, rounds_i, state_i, out_ready_i,
      input  in_ready_o, out_valid_o, state_o
   );

endinterface

// File: rtl/ascon_round_engine_round.sv
// ascon_round: one combinational Ascon-p round.
//   rnd_i         : round index selecting the round constant
//   state_array_i : state before the round
//   state_array_o : state after constant addition, S-box and linear layers
module ascon_round
   import ascon_pkg::*;
(
   input  rnd_t         rnd_i,
   input  ascon_state_t state_array_i,
   output ascon_state_t state_array_o
);

   function automatic ascon_state_t constant_addition_layer(input ascon_state_t s, input rnd_t r);
      ascon_state_t t;
      t          = s;
      t[2][7:0]  = s[2][7:0] ^ ASCON_RC_LUT[r];
      return t;
   endfunction

   // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once.
   function automatic ascon_state_t substitution_layer(input ascon_state_t s);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      ascon_state_t r;
      x0 = s[0] ^ s[4];
      x4 = s[4] ^ s[3];
      x2 = s[2] ^ s[1];
      x1 = s[1];
      x3 = s[3];
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      r  = {x0, x1, x2, x3, x4};
      return r;
   endfunction

   function automatic ascon_state_t linear_layer(input ascon_state_t s);
      ascon_state_t r;
      r[0] = s[0] ^ {s[0][18:0], s[0][63:19]} ^ {s[0][27:0], s[0][63:28]};
      r[1] = s[1] ^ {s[1][60:0], s[1][63:61]} ^ {s[1][38:0], s[1][63:39]};
      r[2] = s[2] ^ {s[2][0],    s[2][63:1]}  ^ {s[2][5:0],  s[2][63:6]};
      r[3] = s[3] ^ {s[3][9:0],  s[3][63:10]} ^ {s[3][16:0], s[3][63:17]};
      r[4] = s[4] ^ {s[4][6:0],  s[4][63:7]}  ^ {s[4][40:0], s[4][63:41]};
      return r;
   endfunction

   assign state_array_o = linear_layer(substitution_layer(constant_addition_layer(state_array_i, rnd_i)));

endmodule

// File: rtl/ascon_round_engine.sv
// ascon_round_engine: iterative Ascon-p[n] permutation, UNROLL rounds per clock.
//   clk_i, rst_i : clock, synchronous active-high reset
//   abort_i      : cancels a running/finished operation (only when
//                  ASCON_ENGINE_ABORT_EN is defined)
//   bus          : slave side of ascon_round_engine_if (request + result)
// Parameter UNROLL: rounds per clock, 1..4.
// Optional feature macro: ASCON_ENGINE_ABORT_EN.
module ascon_round_engine
   import ascon_pkg::*;
#(
   parameter int UNROLL = 1
)(
   input  logic clk_i,
   input  logic rst_i,
`ifdef ASCON_ENGINE_ABORT_EN
   input  logic abort_i,
`endif
   ascon_round_engine_if.slave bus
);

   engine_state_e state_q, state_d;
   ascon_state_t  st_q, st_d;
   rnd_t          idx_q, idx_d;
   rnd_cnt_t      rem_q, rem_d;

   rnd_cnt_t      n_req;
   rnd_cnt_t      step;
   ascon_state_t  chain_out;

   assign n_req = (bus.rounds_i > rnd_cnt_t'(ASCON_MAX_ROUNDS)) ? rnd_cnt_t'(ASCON_MAX_ROUNDS) : bus.rounds_i;
   assign step  = (rem_q > rnd_cnt_t'(UNROLL)) ? rnd_cnt_t'(UNROLL) : rem_q;

   // Round chain: slot j is bypassed when fewer than j+1 rounds remain, so a
   // final partial step applies exactly the outstanding rounds.
   for (genvar j = 0; j < UNROLL; j++) begin : g_round
      ascon_state_t stage_in, round_out, stage_out;
      rnd_t         rnd;
      if (j == 0) begin : g_first
         assign stage_in = st_q;
      end else begin : g_next
         assign stage_in = g_round[j-1].stage_out;
      end
      assign rnd = idx_q + rnd_t'(j);
      ascon_round u_round (
         .rnd_i         (rnd),
         .state_array_i (stage_in),
         .state_array_o (round_out)
      );
      assign stage_out = (rnd_cnt_t'(j) < rem_q) ? round_out : stage_in;
   end

   assign chain_out = g_round[UNROLL-1].stage_out;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         st_q    <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid_i) begin
               st_d    = bus.state_i;
               idx_d   = rnd_t'(ASCON_MAX_ROUNDS) - n_req;
               rem_d   = n_req;
               state_d = (n_req != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            st_d  = chain_out;
            idx_d = (idx_q + step > rnd_t'(ASCON_MAX_ROUNDS)) ? rnd_t'(ASCON_MAX_ROUNDS) : idx_q + step;
            rem_d = (rem_q > step) ? rem_q - step : '0;
            if (rem_q <= step) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef ASCON_ENGINE_ABORT_EN
      // Abort leaves the partially permuted state in the register.
      if (abort_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         st_d    = st_q;
         idx_d   = idx_q;
         rem_d   = rem_q;
      end
`endif
   end

   assign bus.in_ready_o  = (state_q == ST_IDLE);
   assign bus.out_valid_o = (state_q == ST_DONE);
   assign bus.state_o     = st_q;

endmodule

// File: tb/tb_ascon_round_engine.sv
`timescale 1ns/1ps
module tb_ascon_round_engine;
   import ascon_pkg::*;

   localparam int NI = 3;

   // 5-bit S-box table, input/output bit 4 = word x0 ... bit 0 = word x4.
   localparam logic [0:31][4:0] SBOX_T = {
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [3:0]   rounds;
   ascon_state_t st_in;
   logic         out_ready [NI];
`ifdef ASCON_ENGINE_ABORT_EN
   logic         abort;
`endif

   logic         ov [NI];
   logic         ir [NI];
   ascon_state_t so [NI];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ascon_round_engine_if bus1 ();
   ascon_round_engine_if bus2 ();
   ascon_round_engine_if bus4 ();

   assign bus1.in_valid_i = in_valid;  assign bus2.in_valid_i = in_valid;  assign bus4.in_valid_i = in_valid;
   assign bus1.rounds_i   = rounds;    assign bus2.rounds_i   = rounds;    assign bus4.rounds_i   = rounds;
   assign bus1.state_i    = st_in;     assign bus2.state_i    = st_in;     assign bus4.state_i    = st_in;
   assign bus1.out_ready_i = out_ready[0];
   assign bus2.out_ready_i = out_ready[1];
   assign bus4.out_ready_i = out_ready[2];

   assign ov[0] = bus1.out_valid_o;  assign ir[0] = bus1.in_ready_o;  assign so[0] = bus1.state_o;
   assign ov[1] = bus2.out_valid_o;  assign ir[1] = bus2.in_ready_o;  assign so[1] = bus2.state_o;
   assign ov[2] = bus4.out_valid_o;  assign ir[2] = bus4.in_ready_o;  assign so[2] = bus4.state_o;

   ascon_round_engine #(.UNROLL(1)) dut1 (
      .clk_i (clk), .rst_i (rst),
`ifdef ASCON_ENGINE_ABORT_EN
      .abort_i (abort),
`endif
      .bus (bus1));
   ascon_round_engine #(.UNROLL(2)) dut2 (
      .clk_i (clk), .rst_i (rst),
`ifdef ASCON_ENGINE_ABORT_EN
      .abort_i (abort),
`endif
      .bus (bus2));
   ascon_round_engine #(.UNROLL(4)) dut4 (
      .clk_i (clk), .rst_i (rst),
`ifdef ASCON_ENGINE_ABORT_EN
      .abort_i (abort),
`endif
      .bus (bus4));

   // ---------------- reference model ----------------
   function automatic int unr(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   function automatic int exp_lat(input int r, input int u);
      int n;
      n = (r > 12) ? 12 : r;
      return (n == 0) ? 1 : ((n + u - 1) / u + 1);
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
      return (x >> r) | (x << (64 - r));
   endfunction

   // Ascon-p[n]: the last n of the 12 rounds, S-box applied column by column.
   function automatic ascon_state_t model_perm(input ascon_state_t s, input int r);
      logic [63:0] x [5];
      logic [4:0]  sv, sw;
      int          n;
      ascon_state_t res;
      for (int w = 0; w < 5; w++) x[w] = s[w];
      n = (r > 12) ? 12 : r;
      for (int i = 12 - n; i < 12; i++) begin
         x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
         for (int b = 0; b < 64; b++) begin
            sv = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            sw = SBOX_T[sv];
            x[0][b] = sw[4]; x[1][b] = sw[3]; x[2][b] = sw[2]; x[3][b] = sw[1]; x[4][b] = sw[0];
         end
         x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
         x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
         x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
         x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
         x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
      end
      for (int w = 0; w < 5; w++) res[w] = x[w];
      return res;
   endfunction

   function automatic ascon_state_t rand_state();
      ascon_state_t s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
      return s;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one request to all three engines, collect each result and latency.
   task automatic run_txn(input logic [3:0] r, input ascon_state_t s, input ascon_state_t exp, input string tag);
      int           lat  [NI];
      ascon_state_t got  [NI];
      bit           seen [NI];
      int           nseen;
      nseen = 0;
      for (int i = 0; i < NI; i++) begin
         lat[i] = 0; got[i] = '0; seen[i] = 1'b0; out_ready[i] = 1'b1;
      end
      in_valid = 1'b1; rounds = r; st_in = s;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         for (int i = 0; i < NI; i++) begin
            if (!seen[i] && ov[i]) begin
               seen[i] = 1'b1; lat[i] = c; got[i] = so[i]; nseen++;
            end
         end
         if (nseen == NI) break;
         tick();
      end
      tick();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s_lat_u%0d", tag, unr(i)), 320'(lat[i]), 320'(exp_lat(int'(r), unr(i))));
         chk($sformatf("%s_state_u%0d", tag, unr(i)), got[i], exp);
         chk($sformatf("%s_idle_u%0d", tag, unr(i)), 320'(ir[i]), 320'(1));
      end
   endtask

   typedef struct {
      logic [3:0]   rounds;
      ascon_state_t st;
      ascon_state_t exp;
   } vec_t;

   vec_t         vecs [8];
   ascon_state_t s_a, s_b, exp_a;
   logic [3:0]   rr;

   initial begin
      // Vector table
      vecs[0].rounds = 4'd12; vecs[0].st = '0;
      vecs[1].rounds = 4'd6;  vecs[1].st = rand_state();
      vecs[2].rounds = 4'd0;  vecs[2].st = rand_state();
      vecs[3].rounds = 4'd15; vecs[3].st = rand_state();
      vecs[4].rounds = 4'd1;  vecs[4].st = rand_state();
      vecs[5].rounds = 4'd5;  vecs[5].st = rand_state();
      vecs[6].rounds = 4'd8;  vecs[6].st = rand_state();
      vecs[7].rounds = 4'd13; vecs[7].st = rand_state();
      for (int v = 0; v < 8; v++) vecs[v].exp = model_perm(vecs[v].st, int'(vecs[v].rounds));

      in_valid = 1'b0; rounds = '0; st_in = '0;
      for (int i = 0; i < NI; i++) out_ready[i] = 1'b0;
`ifdef ASCON_ENGINE_ABORT_EN
      abort = 1'b0;
`endif

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_in_ready_u%0d", unr(i)), 320'(ir[i]), 320'(1));
         chk($sformatf("rst_out_valid_u%0d", unr(i)), 320'(ov[i]), 320'(0));
         chk($sformatf("rst_state_u%0d", unr(i)), so[i], '0);
      end

      // Table-driven vectors
      for (int v = 0; v < 8; v++)
         run_txn(vecs[v].rounds, vecs[v].st, vecs[v].exp, $sformatf("vec%0d", v));

      // Randomized requests
      for (int k = 0; k < 10; k++) begin
         rr  = 4'($urandom_range(0, 15));
         s_a = rand_state();
         run_txn(rr, s_a, model_perm(s_a, int'(rr)), $sformatf("rnd%0d", k));
      end

      // Backpressure in DONE, ignored request, simultaneous ready+valid
      s_a   = rand_state();
      exp_a = model_perm(s_a, 5);
      for (int i = 0; i < NI; i++) out_ready[i] = 1'b0;
      in_valid = 1'b1; rounds = 4'd5; st_in = s_a;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (ov[0] && ov[1] && ov[2]) break;
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            in_valid = 1'b1; rounds = 4'd2; st_in = rand_state();
         end
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("bp%0d_valid_u%0d", c, unr(i)), 320'(ov[i]), 320'(1));
            chk($sformatf("bp%0d_ready_u%0d", c, unr(i)), 320'(ir[i]), 320'(0));
            chk($sformatf("bp%0d_state_u%0d", c, unr(i)), so[i], exp_a);
         end
      end
      s_b = rand_state();
      in_valid = 1'b1; rounds = 4'd3; st_in = s_b;
      for (int i = 0; i < NI; i++) out_ready[i] = 1'b1;
      tick();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("simul_valid_u%0d", unr(i)), 320'(ov[i]), 320'(0));
         chk($sformatf("simul_idle_u%0d", unr(i)), 320'(ir[i]), 320'(1));
         chk($sformatf("simul_keep_u%0d", unr(i)), so[i], exp_a);
      end
      run_txn(4'd3, s_b, model_perm(s_b, 3), "after_bp");

      // Reset during the second RUN cycle
      s_a = rand_state();
      in_valid = 1'b1; rounds = 4'd8; st_in = s_a;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NI; i++)
         chk($sformatf("mrst_run1_valid_u%0d", unr(i)), 320'(ov[i]), 320'(0));
      tick();
      for (int i = 0; i < NI; i++)
         chk($sformatf("mrst_run2_valid_u%0d", unr(i)), 320'(ov[i]), 320'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("mrst%0d_valid_u%0d", c, unr(i)), 320'(ov[i]), 320'(0));
            chk($sformatf("mrst%0d_ready_u%0d", c, unr(i)), 320'(ir[i]), 320'(1));
            if (c == 0) chk($sformatf("mrst_state_u%0d", unr(i)), so[i], '0);
         end
         tick();
      end
      s_b = rand_state();
      run_txn(4'd8, s_b, model_perm(s_b, 8), "after_rst");

`ifdef ASCON_ENGINE_ABORT_EN
      // Abort during the second RUN cycle
      in_valid = 1'b1; rounds = 4'd8; st_in = rand_state();
      tick();
      in_valid = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("abort%0d_valid_u%0d", c, unr(i)), 320'(ov[i]), 320'(0));
            chk($sformatf("abort%0d_ready_u%0d", c, unr(i)), 320'(ir[i]), 320'(1));
         end
         tick();
      end
      s_b = rand_state();
      run_txn(4'd7, s_b, model_perm(s_b, 7), "after_abort");
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
